tnoc_axi_read_responder: RTL
============================

# tnoc_axi_read_responder

AXI read-channel responder (slave end) for the tnoc AXI adapters. Accepts one AR request at a time, computes per-beat addresses for FIXED, INCREMENTING and WRAP bursts, and issues single-cycle reads to a local fixed-latency memory port. Returns R beats with ID, data, response and last flag. Sits at the target side of the NoC, behind the AXI slave adapter, in front of SRAM/register storage.

## Interface
- AXI_CONFIG, tnoc_axi_pkg::TNOC_DEFAULT_AXI_CONFIG, supplies id_width, address_width and data_width.
- i_clk  in  1  clock; one clock; reset is synchronous and active-high
- i_rst  in  1  synchronous active-high reset
- i_arvalid  in  1  AR valid
- o_arready  out  1  AR ready
- i_arid  in  id_width  AR ID
- i_araddr  in  address_width  start address
- i_arlen  in  8  tnoc_axi_burst_length (beats-1)
- i_arsize  in  3  tnoc_axi_burst_size
- i_arburst  in  2  tnoc_axi_burst_type
- o_rvalid  out  1  R valid
- i_rready  in  1  R ready
- o_rid  out  id_width  echo of captured arid
- o_rdata  out  data_width  read data
- o_rresp  out  2  tnoc_axi_response
- o_rlast  out  1  final beat
- o_mem_read  out  1  memory read strobe
- o_mem_address  out  address_width  memory address
- i_mem_data  in  data_width  read data, valid the cycle after o_mem_read
- i_mem_error  in  1  access error, same timing as i_mem_data

## Operation
- States: IDLE, ISSUE, CAPTURE, DATA, ERROR.
- IDLE: o_arready=1. On AR handshake, capture id, addr, size, burst and unpacked length (unpack_burst_length). Legal request -> ISSUE. Illegal request -> ERROR.
- Illegal requests:
  - (1<<arsize) > data_width/8.
  - arburst==3 (reserved).
  - WRAP with length not in {2,4,8,16}.
- ISSUE: o_mem_read=1, o_mem_address=current address. Next state CAPTURE.
- CAPTURE: register i_mem_data into o_rdata. o_rresp=SLAVE_ERROR if i_mem_error, else OKAY. Next state DATA.
- DATA: o_rvalid=1. On handshake:
  - last beat -> IDLE.
  - otherwise advance address, decrement count, and go to CAPTURE with o_mem_read=1 in that same cycle.
- ERROR: no memory reads. o_rvalid=1 continuously with o_rresp=SLAVE_ERROR and o_rdata=0; one beat per handshake. After the last beat -> IDLE.
- Address advance, with B=1<<size:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(B-1)) + B; an unaligned start aligns after beat 0.
  - WRAP: W=len*B; next = (addr & ~(W-1)) | ((addr+B) & (W-1)).
- Arithmetic is modulo 2^address_width; INCR wraps silently at the top of the address space.
- o_rlast=1 exactly when the remaining count is 1 and o_rvalid=1.

## Timing
- Reset values: o_arready=1 (IDLE), o_rvalid=0, o_rlast=0, o_rresp=OKAY, o_rid=0, o_rdata=0, o_mem_read=0, o_mem_address=0.
- Reset mid-burst abandons the burst; no further beats are emitted.
- AR handshake at cycle T:
  - o_mem_read at T+1.
  - o_rvalid at T+3 (T+2 capture, registered output).
- Legal bursts: at best one beat per 2 cycles; o_rvalid drops for one cycle between beats.
- Error bursts: first beat at T+1, then back-to-back beats under continuous i_rready.
- o_rvalid, once asserted, holds with stable payload until i_rready.
- o_arready is low from the handshake cycle+1 until the cycle after the last R handshake; AR is never accepted in the same cycle as an R handshake.

## Configuration
- TNOC_AXI_READ_RESPONDER_WRAP_EN defined: WRAP bursts are supported as described.
- Not defined: every WRAP request is illegal and is answered through ERROR with SLAVE_ERROR on every beat. The WRAP address logic is not compiled.

## Structure
- tnoc_axi_pkg additions:
  - state enum tnoc_axi_read_responder_state.
  - function is_legal_wrap_length(tnoc_axi_unpacked_burst_length).
  - function calc_next_burst_address(addr, size, burst, length), width from address_width parameter via a parameterized class/let or a localparam-maximum width.
- Sub-module tnoc_axi_burst_address_generator: holds the current address register and beat counter; inputs load/advance; outputs address and last.

## Test plan
- INCR, araddr=0x1000, arlen=3, arsize=2, 32-bit data -> mem addresses 0x1000, 0x1004, 0x1008, 0x100C; 4 beats OKAY; rlast on beat 4; rid echoed.
- WRAP, araddr=0x1008, arlen=3, arsize=2 -> addresses 0x1008, 0x100C, 0x1000, 0x1004. With the macro undefined: 4 SLAVE_ERROR beats, no o_mem_read.
- FIXED, araddr=0x20, arlen=2 -> three reads of 0x20. i_mem_error on beat 2 only -> rresp OKAY, SLAVE_ERROR, OKAY.
- Illegal arsize=3 with 32-bit data, arlen=1 -> two SLAVE_ERROR beats on consecutive cycles, rdata=0, no memory reads.
- i_rready low for 5 cycles on beat 1 -> rvalid held, payload stable, no extra o_mem_read. i_rst asserted mid-burst -> next cycle rvalid=0, arready=1.
- Unaligned INCR araddr=0x1003, arsize=2, arlen=1 -> addresses 0x1003, 0x1004. Back-to-back AR accepted only after the prior rlast handshake.

Source files
------------

// File: rtl/tnoc_axi_pkg.sv
// tnoc AXI shared types and burst helpers.
// Optional TNOC_AXI_READ_RESPONDER_WRAP_EN enables WRAP bursts.
package tnoc_axi_pkg;

  typedef struct packed {
    int id_width;
    int address_width;
    int data_width;
  } tnoc_axi_config;

  localparam tnoc_axi_config TNOC_DEFAULT_AXI_CONFIG = '{
    id_width:      4,
    address_width: 32,
    data_width:    32
  };

  localparam int TNOC_AXI_MAX_ADDRESS_WIDTH = 64;

  typedef logic [TNOC_AXI_MAX_ADDRESS_WIDTH-1:0] tnoc_axi_max_address;
  typedef logic [7:0] tnoc_axi_burst_length;
  typedef logic [8:0] tnoc_axi_unpacked_burst_length;
  typedef logic [2:0] tnoc_axi_burst_size;

  typedef enum logic [1:0] {
    TNOC_AXI_FIXED_BURST        = 2'd0,
    TNOC_AXI_INCREMENTING_BURST = 2'd1,
    TNOC_AXI_WRAPPING_BURST     = 2'd2,
    TNOC_AXI_RESERVED_BURST     = 2'd3
  } tnoc_axi_burst_type;

  typedef enum logic [1:0] {
    TNOC_AXI_OKAY         = 2'd0,
    TNOC_AXI_EXOKAY       = 2'd1,
    TNOC_AXI_SLAVE_ERROR  = 2'd2,
    TNOC_AXI_DECODE_ERROR = 2'd3
  } tnoc_axi_response;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_DATA,
    RD_ERROR
  } tnoc_axi_read_responder_state;

  function automatic tnoc_axi_unpacked_burst_length
    unpack_burst_length(input tnoc_axi_burst_length len);
    return {1'b0, len} + 9'd1;
  endfunction

  function automatic logic is_legal_wrap_length(
    input tnoc_axi_unpacked_burst_length len
  );
    return (len == 9'd2) || (len == 9'd4) ||
           (len == 9'd8) || (len == 9'd16);
  endfunction

  function automatic tnoc_axi_max_address calc_next_burst_address(
    input tnoc_axi_max_address           addr,
    input tnoc_axi_burst_size            size,
    input tnoc_axi_burst_type            burst,
    input tnoc_axi_unpacked_burst_length length
  );
    tnoc_axi_max_address b;
    tnoc_axi_max_address w;
    tnoc_axi_max_address next;
    b    = tnoc_axi_max_address'(1) << size;
    w    = b * tnoc_axi_max_address'(length);
    next = addr;
    case (burst)
      TNOC_AXI_INCREMENTING_BURST:
        next = (addr & ~(b - 1)) + b;
`ifdef TNOC_AXI_READ_RESPONDER_WRAP_EN
      TNOC_AXI_WRAPPING_BURST:
        next = (addr & ~(w - 1)) | ((addr + b) & (w - 1));
`endif
      default:
        next = addr;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/tnoc_axi_read_responder_burst_address_generator.sv
// Current-beat address register and remaining-beat counter.
// WRAP stepping only when TNOC_AXI_READ_RESPONDER_WRAP_EN is defined.
module tnoc_axi_burst_address_generator
  import tnoc_axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic                          advance_i,
  input  logic [ADDRESS_WIDTH-1:0]      address_i,
  input  tnoc_axi_burst_size            size_i,
  input  tnoc_axi_burst_type            burst_i,
  input  tnoc_axi_unpacked_burst_length length_i,
  output logic [ADDRESS_WIDTH-1:0]      address_o,
  output logic [ADDRESS_WIDTH-1:0]      next_address_o,
  output logic                          last_o
);

  logic [ADDRESS_WIDTH-1:0]      address_q;
  logic [ADDRESS_WIDTH-1:0]      address_d;
  tnoc_axi_unpacked_burst_length count_q;
  tnoc_axi_burst_size            size_q;
  tnoc_axi_burst_type            burst_q;
  tnoc_axi_unpacked_burst_length length_q;

  always_comb begin
    address_d = ADDRESS_WIDTH'(calc_next_burst_address(
      TNOC_AXI_MAX_ADDRESS_WIDTH'(address_q),
      size_q, burst_q, length_q
    ));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      address_q <= '0;
      count_q   <= '0;
      size_q    <= '0;
      burst_q   <= TNOC_AXI_FIXED_BURST;
      length_q  <= '0;
    end else if (load_i) begin
      address_q <= address_i;
      count_q   <= length_i;
      size_q    <= size_i;
      burst_q   <= burst_i;
      length_q  <= length_i;
    end else if (advance_i) begin
      address_q <= address_d;
      count_q   <= count_q - 9'd1;
    end
  end

  assign address_o      = address_q;
  assign next_address_o = address_d;
  assign last_o         = (count_q == 9'd1);

endmodule

// File: rtl/tnoc_axi_read_responder.sv
// AXI read responder: AR capture, burst reads to a 1-cycle memory, R beats.
// Optional TNOC_AXI_READ_RESPONDER_WRAP_EN enables WRAP bursts.
module tnoc_axi_read_responder
  import tnoc_axi_pkg::*;
#(
  parameter tnoc_axi_config AXI_CONFIG = TNOC_DEFAULT_AXI_CONFIG
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_arvalid,
  output logic                                o_arready,
  input  logic [AXI_CONFIG.id_width-1:0]      i_arid,
  input  logic [AXI_CONFIG.address_width-1:0] i_araddr,
  input  logic [7:0]                          i_arlen,
  input  logic [2:0]                          i_arsize,
  input  logic [1:0]                          i_arburst,
  output logic                                o_rvalid,
  input  logic                                i_rready,
  output logic [AXI_CONFIG.id_width-1:0]      o_rid,
  output logic [AXI_CONFIG.data_width-1:0]    o_rdata,
  output logic [1:0]                          o_rresp,
  output logic                                o_rlast,
  output logic                                o_mem_read,
  output logic [AXI_CONFIG.address_width-1:0] o_mem_address,
  input  logic [AXI_CONFIG.data_width-1:0]    i_mem_data,
  input  logic                                i_mem_error
);

  localparam int IW = AXI_CONFIG.id_width;
  localparam int AW = AXI_CONFIG.address_width;
  localparam int DW = AXI_CONFIG.data_width;

  tnoc_axi_read_responder_state  state_q;
  tnoc_axi_read_responder_state  state_d;
  logic [IW-1:0]                 rid_q;
  logic [DW-1:0]                 rdata_q;
  tnoc_axi_response              rresp_q;
  tnoc_axi_burst_type            ar_burst;
  tnoc_axi_unpacked_burst_length ar_length;
  logic                          size_ok;
  logic                          wrap_ok;
  logic                          legal;
  logic                          load;
  logic                          advance;
  logic                          last;
  logic [AW-1:0]                 cur_addr;
  logic [AW-1:0]                 next_addr;

  assign ar_burst  = tnoc_axi_burst_type'(i_arburst);
  assign ar_length = unpack_burst_length(i_arlen);
  assign size_ok   = (32'd1 << i_arsize) <= 32'(DW / 8);

`ifdef TNOC_AXI_READ_RESPONDER_WRAP_EN
  assign wrap_ok = is_legal_wrap_length(ar_length);
`else
  assign wrap_ok = 1'b0;
`endif

  assign legal = size_ok &&
                 (ar_burst != TNOC_AXI_RESERVED_BURST) &&
                 ((ar_burst != TNOC_AXI_WRAPPING_BURST) || wrap_ok);

  tnoc_axi_burst_address_generator #(
    .ADDRESS_WIDTH (AW)
  ) u_addr_gen (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .load_i         (load),
    .advance_i      (advance),
    .address_i      (i_araddr),
    .size_i         (i_arsize),
    .burst_i        (ar_burst),
    .length_i       (ar_length),
    .address_o      (cur_addr),
    .next_address_o (next_addr),
    .last_o         (last)
  );

  always_comb begin
    state_d    = state_q;
    o_arready  = 1'b0;
    o_rvalid   = 1'b0;
    o_mem_read = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) begin
          load    = 1'b1;
          state_d = legal ? RD_ISSUE : RD_ERROR;
        end
      end
      RD_ISSUE: begin
        o_mem_read = 1'b1;
        state_d    = RD_CAPTURE;
      end
      RD_CAPTURE: state_d = RD_DATA;
      RD_DATA: begin
        o_rvalid = 1'b1;
        if (i_rready) begin
          if (last) begin
            state_d = RD_IDLE;
          end else begin
            advance    = 1'b1;
            o_mem_read = 1'b1;
            state_d    = RD_CAPTURE;
          end
        end
      end
      RD_ERROR: begin
        o_rvalid = 1'b1;
        if (i_rready) begin
          if (last) state_d = RD_IDLE;
          else      advance = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Reads issued from DATA target the address the counter is stepping to.
  always_comb begin
    o_mem_address = '0;
    if (o_mem_read) begin
      o_mem_address = (state_q == RD_DATA) ? next_addr : cur_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RD_IDLE;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= TNOC_AXI_OKAY;
    end else begin
      state_q <= state_d;
      if (load) rid_q <= i_arid;
      if (state_q == RD_CAPTURE) begin
        rdata_q <= i_mem_data;
        rresp_q <= i_mem_error ? TNOC_AXI_SLAVE_ERROR : TNOC_AXI_OKAY;
      end
    end
  end

  always_comb begin
    o_rresp = TNOC_AXI_OKAY;
    unique case (state_q)
      RD_DATA:  o_rresp = rresp_q;
      RD_ERROR: o_rresp = TNOC_AXI_SLAVE_ERROR;
      default:  o_rresp = TNOC_AXI_OKAY;
    endcase
  end

  assign o_rid   = rid_q;
  assign o_rdata = (state_q == RD_DATA) ? rdata_q : '0;
  assign o_rlast = o_rvalid && last;

endmodule
